pipelined_chunk_adder: RTL and testbench
========================================

// Module: pipelined_chunk_adder
// PURPOSE
//  Signed/unsigned add-subtract unit, pipelined in CHUNK-bit ripple slices, one slice per stage.
//  Successor to the one-bit-per-stage ripple pipeline. Adds:
//   - configurable slice width;
//   - subtract mode;
//   - signed overflow flag;
//   - valid/ready handshake with backpressure.
//  Sits in the datapath between operand staging and the result writeback buffer.
// PARAMETERS
//  WIDTH   64  operand/result width in bits
//  CHUNK    8  bits summed per stage; WIDTH % CHUNK != 0 -> $error at elaboration
//  STAGES  WIDTH/CHUNK  localparam, pipeline depth; CHUNK==WIDTH -> 1 stage
// PORTS
//  clk        in   1      clock, rising edge
//  arst       in   1      asynchronous reset, active-high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit accepts a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (borrow-in when sub=1)
//  sub        in   1      1: A-B, 0: A+B
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      two's-complement overflow
// BEHAVIOUR
//  - Reset (arst=1, async assert): all stage valids, out_valid, sum, cout, ovf -> 0; data regs -> 0.
//    in_ready=1 from first cycle after arst deasserts. Reset mid-operation discards in-flight beats.
//  - Operand prep at input: b_eff = sub ? ~b : b; c0 = cin ^ sub.
//    Hence sub=1,cin=0 -> A-B; sub=1,cin=1 -> A-B-1.
//  - Stage k (0..STAGES-1): sums bits [k*CHUNK +: CHUNK] of a and b_eff with the registered carry.
//    Writes the slice result into the forwarded sum vector; forwards carry.
//    Bits below the slice are already final; bits above pass through unmodified.
//  - Last stage also captures carry into MSB. ovf = c_in_msb ^ c_out_msb; cout = c_out_msb.
//  - Latency: a beat accepted at edge N appears on out_valid/sum at edge N+STAGES if no stall.
//    Throughput 1 beat/cycle.
//  - Handshake: adv = out_ready | ~out_valid; in_ready = adv (combinational).
//    - Transfer in: in_valid & in_ready.
//    - Transfer out: out_valid & out_ready.
//    - All stages shift together only when adv=1. adv=0 freezes every stage incl. outputs; no bubble collapse.
//    - Stage 0 loads a bubble (valid=0) when adv & ~in_valid.
//  - sum/cout/ovf held stable while out_valid & ~out_ready.
//  - Simultaneous transfer in and out in one cycle is legal and loses nothing.
//  - Inputs are ignored when in_ready=0. Beats never reorder or duplicate.
//  - Unsigned callers ignore ovf; signed callers ignore cout.
// CONFIGURATION
//  ADDER_SAT_EN defined:
//   - On ovf=1, sum saturates using the A sign bit carried to the last stage:
//     a[WIDTH-1]=0 -> 0111..1; a[WIDTH-1]=1 -> 1000..0.
//   - cout and ovf are still reported unsaturated; latency unchanged.
//  ADDER_SAT_EN undefined: sum is the modulo-2^WIDTH result; no saturation logic present.
// TESTING (WIDTH=16, CHUNK=4, out_ready=1 unless stated)
//  1. a=7FFF b=0001 sub=0 cin=0 -> after 4 cycles: sum=8000 cout=0 ovf=1 (ADDER_SAT_EN: sum=7FFF).
//  2. a=FFFF b=0001 sub=0 cin=0 -> sum=0000 cout=1 ovf=0. Then cin=1 -> sum=0001 cout=1.
//  3. a=0005 b=0007 sub=1 cin=0 -> sum=FFFE cout=0 ovf=0.
//     a=8000 b=0001 sub=1 -> sum=7FFF ovf=1 (ADDER_SAT_EN: sum=8000).
//  4. Stream 8 random beats back-to-back, drop out_ready for 3 cycles mid-stream:
//     - in_ready low exactly while out_valid & ~out_ready;
//     - outputs held stable;
//     - all 8 results match the model, in order.
//  5. Assert arst with 3 beats in flight -> out_valid=0, sum=0 immediately.
//     After release, none of the old beats emerge; a new beat returns after 4 cycles.
//  6. CHUNK=1 and CHUNK=16 builds: 1000 random beats each vs reference model.
//     Latency 16 and 1 cycles respectively. WIDTH=16, CHUNK=5 fails elaboration.

Source files
------------

// File: rtl/pipelined_chunk_adder.sv
// Add/subtract unit pipelined in CHUNK-bit ripple slices with a valid/ready handshake.
// Optional ADDER_SAT_EN: saturate sum on signed overflow (cout/ovf still reported raw).
module pipelined_chunk_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  // Rank k holds a beat whose slices below k are already summed into s_q[k].
  logic [STAGES-1:0]            vld_q;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] s_q;
  logic [STAGES-1:0][WIDTH-1:0] s_nx;
  logic [STAGES-1:0]            c_nx;

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    localparam logic [WIDTH-1:0] SliceMask = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);
    logic [CHUNK:0] slice;

    assign slice = {1'b0, a_q[k][k*CHUNK +: CHUNK]} + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_q[k]};
    assign s_nx[k] = (s_q[k] & ~SliceMask) | (WIDTH'(slice[CHUNK-1:0]) << (k * CHUNK));
    assign c_nx[k] = slice[CHUNK];
  end

  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] res_sum;
  logic             msb_a;
  logic             ovf_nx;

  assign raw_sum = s_nx[STAGES-1];
  assign msb_a   = a_q[STAGES-1][WIDTH-1];
  // a ^ b ^ s at the MSB recovers the carry into the MSB.
  assign ovf_nx  = msb_a ^ b_q[STAGES-1][WIDTH-1] ^ raw_sum[WIDTH-1] ^ c_nx[STAGES-1];

`ifdef ADDER_SAT_EN
  assign res_sum = ovf_nx ? {msb_a, {(WIDTH-1){~msb_a}}} : raw_sum;
`else
  assign res_sum = raw_sum;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      vld_q     <= '0;
      c_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      a_q[0]   <= a;
      b_q[0]   <= sub ? ~b : b;
      s_q[0]   <= '0;
      c_q[0]   <= cin ^ sub;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        s_q[k]   <= s_nx[k-1];
        c_q[k]   <= c_nx[k-1];
      end
      out_valid <= vld_q[STAGES-1];
      sum       <= res_sum;
      cout      <= c_nx[STAGES-1];
      ovf       <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Scoreboard bench for pipelined_chunk_adder (WIDTH=16, CHUNK=4): driver pushes model
// results, an independent monitor pops and compares on every output transfer.
module tb_pipelined_chunk_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  pipelined_chunk_adder #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   acc_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Integer arithmetic reference: unsigned result for sum/cout, signed range test for ovf.
  function automatic res_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic sv, input logic cv);
    longint ua = av;
    longint ub = bv;
    longint sa = $signed(av);
    longint sb = $signed(bv);
    longint c  = cv;
    longint u;
    longint s;
    res_t   r;
    if (sv) begin
      u      = ua - ub - c;
      s      = sa - sb - c;
      r.cout = (u >= 0);
    end else begin
      u      = ua + ub + c;
      s      = sa + sb + c;
      r.cout = (u > 65535);
    end
    r.sum = u[15:0];
    r.ovf = (s > 32767) || (s < -32768);
`ifdef ADDER_SAT_EN
    if (r.ovf) r.sum = av[15] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  function automatic logic [15:0] pick();
    logic [15:0] corner[4];
    corner = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
    if ($urandom_range(0, 4) == 0) return corner[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  // Monitor: output compare, handshake rule and stall-hold stability.
  initial begin
    res_t e;
    res_t held;
    bit   stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (arst) begin
        stalled = 1'b0;
        continue;
      end
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (stalled) check("stall_hold", {out_valid, sum, cout, ovf}, {1'b1, held});
      stalled = out_valid && !out_ready;
      held    = {sum, cout, ovf};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_output: got sum=%h, want no output (t=%0t)", sum, $time);
        end else begin
          e = exp_q.pop_front();
          check("result", {sum, cout, ovf}, e);
        end
      end
    end
  end

  // One cycle of random traffic; an offered beat stays asserted until accepted.
  task automatic step(input bit offer, input bit ordy, output bit acc);
    @(negedge clk);
    if (acc_prev) in_valid = 1'b0;
    out_ready = ordy;
    if (!in_valid && offer) begin
      a        = pick();
      b        = pick();
      sub      = 1'($urandom);
      cin      = 1'($urandom);
      in_valid = 1'b1;
    end
    #1;
    acc      = in_valid && in_ready;
    acc_prev = acc;
    if (acc) exp_q.push_back(model(a, b, sub, cin));
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    in_valid  = 1'b0;
    acc_prev  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (STAGES + 2) @(negedge clk);
  endtask

  task automatic send_single(input logic [15:0] av, input logic [15:0] bv,
                             input logic sv, input logic cv);
    int lat;
    drain();
    a        = av;
    b        = bv;
    sub      = sv;
    cin      = cv;
    in_valid = 1'b1;
    #1;
    check("single_accept", in_ready, 1'b1);
    exp_q.push_back(model(av, bv, sv, cv));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("latency", lat, STAGES);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int cnt;
    int cyc;

    repeat (2) @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_sum", {sum, cout, ovf}, 18'h0);
    #3;
    arst = 1'b0;
    @(negedge clk);
    #1;
    check("ready_after_reset", in_ready, 1'b1);

    // Directed corner cases.
    send_single(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send_single(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send_single(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    send_single(16'h0005, 16'h0007, 1'b1, 1'b0);
    send_single(16'h8000, 16'h0001, 1'b1, 1'b0);
    send_single(16'h0005, 16'h0007, 1'b1, 1'b1);

    // Eight back-to-back beats with a three-cycle output stall mid-stream.
    drain();
    cnt = 0;
    cyc = 0;
    while (cnt < 8 && cyc < 100) begin
      step(1'b1, !(cyc >= 5 && cyc < 8), acc);
      cnt += int'(acc);
      cyc++;
    end
    check("stream_8_accepted", cnt, 8);
    drain();

    // Reset with three beats in flight.
    cnt = 0;
    cyc = 0;
    while (cnt < 3 && cyc < 50) begin
      step(1'b1, 1'b1, acc);
      cnt += int'(acc);
      cyc++;
    end
    @(posedge clk);
    #3;
    arst = 1'b1;
    exp_q.delete();
    in_valid = 1'b0;
    acc_prev = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_outputs", {sum, cout, ovf}, 18'h0);
    repeat (2) @(negedge clk);
    #3;
    arst = 1'b0;
    @(negedge clk);
    #1;
    check("ready_after_midrst", in_ready, 1'b1);
    repeat (10) @(negedge clk);
    send_single(16'h1234, 16'h4321, 1'b0, 1'b1);

    // Random traffic with random backpressure.
    drain();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
